// File: rtl/load_store_queue.sv
// In-order load/store queue: dispatch enqueues at the tail, the AGU fills address/data by ROB id,
// and the memory stage reads the head combinationally and pops it once the cache access is done.
module load_store_queue #(
  parameter int unsigned DEPTH_BITS     = 3,
  parameter int unsigned ROB_DEPTH_BITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rob_flush,
  // dispatch
  input  logic                      i_enq_valid,
  input  logic                      i_enq_is_load,
  input  logic [2:0]                i_enq_funct3,
  input  logic [ROB_DEPTH_BITS-1:0] i_enq_rob_id,
  input  logic [4:0]                i_enq_ar_dest,
  input  logic [5:0]                i_enq_pr_dest,
  output logic                      o_full,
  output logic [DEPTH_BITS:0]       o_elemcount,
  // address generation
  input  logic                      i_agu_valid,
  input  logic [ROB_DEPTH_BITS-1:0] i_agu_rob_id,
  input  logic [31:0]               i_agu_addr,
  input  logic [31:0]               i_agu_rs1_rdata,
  input  logic [31:0]               i_agu_rs2_rdata,
  // head entry
  output logic                      o_head_is_load,
  output logic [2:0]                o_head_funct3,
  output logic [ROB_DEPTH_BITS-1:0] o_head_rob_id,
  output logic [4:0]                o_head_ar_dest,
  output logic [5:0]                o_head_pr_dest,
  output logic                      o_head_ready,
  output logic [31:0]               o_head_addr,
  output logic [3:0]                o_head_mask,
  output logic [31:0]               o_head_wdata,
  output logic [31:0]               o_head_rs1_rdata,
  output logic [31:0]               o_head_rs2_rdata,
  input  logic                      i_dequeue
);

  localparam int unsigned DEPTH_N = 1 << DEPTH_BITS;
  localparam int unsigned CNT_W   = DEPTH_BITS + 1;

  // Byte-lane mask for an access of size funct3[1:0] at byte offset off.
  function automatic logic [3:0] f_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_mask = 4'b0001 << off;
      2'b01:   f_mask = off[1] ? 4'b1100 : 4'b0011;
      default: f_mask = 4'b1111;
    endcase
  endfunction

  // Store data moved onto the lanes selected by f_mask.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [1:0] off,
                                          input logic [31:0] rs2);
    case (size)
      2'b00:   f_wdata = rs2 << {off, 3'b000};
      2'b01:   f_wdata = off[1] ? {rs2[15:0], 16'h0000} : rs2;
      default: f_wdata = rs2;
    endcase
  endfunction

  logic [DEPTH_N-1:0]        r_valid;
  logic [DEPTH_N-1:0]        r_ready;
  logic                      r_is_load [DEPTH_N];
  logic [2:0]                r_funct3  [DEPTH_N];
  logic [ROB_DEPTH_BITS-1:0] r_rob_id  [DEPTH_N];
  logic [4:0]                r_ar_dest [DEPTH_N];
  logic [5:0]                r_pr_dest [DEPTH_N];
  logic [31:0]               r_addr    [DEPTH_N];
  logic [3:0]                r_mask    [DEPTH_N];
  logic [31:0]               r_wdata   [DEPTH_N];
  logic [31:0]               r_rs1     [DEPTH_N];
  logic [31:0]               r_rs2     [DEPTH_N];

  logic [DEPTH_BITS-1:0]     r_head;
  logic [DEPTH_BITS-1:0]     r_tail;
  logic [CNT_W-1:0]          r_count;
  logic                      r_full;

  logic                      w_enq_acc;
  logic                      w_deq_acc;
  logic [CNT_W-1:0]          w_count_nxt;
  logic [DEPTH_N-1:0]        w_match;

  // full is registered, so a same-cycle dequeue never makes room for an enqueue
  assign w_enq_acc = i_enq_valid && !r_full;
  assign w_deq_acc = i_dequeue && (r_count != '0);

  // AGU lookup across live entries; flush suppresses the update
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < DEPTH_N; i++) begin
      w_match[i] = i_agu_valid && !i_rob_flush && r_valid[i] && (r_rob_id[i] == i_agu_rob_id);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq_acc && !w_deq_acc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_deq_acc && !w_enq_acc) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Control state: flush behaves exactly like reset and wins over everything else
  always_ff @(posedge i_clk) begin
    if (i_rst || i_rob_flush) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_ready <= r_ready | w_match;
      if (w_enq_acc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + DEPTH_BITS'(1);
      end
      if (w_deq_acc) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + DEPTH_BITS'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH_N));
    end
  end

  // Entry payload; qualified by valid/ready so it needs no reset
  always_ff @(posedge i_clk) begin
    if (w_enq_acc) begin
      r_is_load[r_tail] <= i_enq_is_load;
      r_funct3[r_tail]  <= i_enq_funct3;
      r_rob_id[r_tail]  <= i_enq_rob_id;
      r_ar_dest[r_tail] <= i_enq_ar_dest;
      r_pr_dest[r_tail] <= i_enq_pr_dest;
    end
    for (int unsigned i = 0; i < DEPTH_N; i++) begin
      if (w_match[i]) begin
        r_addr[i]  <= i_agu_addr;
        r_rs1[i]   <= i_agu_rs1_rdata;
        r_rs2[i]   <= i_agu_rs2_rdata;
        r_mask[i]  <= f_mask(r_funct3[i][1:0], i_agu_addr[1:0]);
        r_wdata[i] <= f_wdata(r_funct3[i][1:0], i_agu_addr[1:0], i_agu_rs2_rdata);
      end
    end
  end

  assign o_full           = r_full;
  assign o_elemcount      = r_count;
  assign o_head_is_load   = r_is_load[r_head];
  assign o_head_funct3    = r_funct3[r_head];
  assign o_head_rob_id    = r_rob_id[r_head];
  assign o_head_ar_dest   = r_ar_dest[r_head];
  assign o_head_pr_dest   = r_pr_dest[r_head];
  assign o_head_ready     = r_valid[r_head] && r_ready[r_head];
  assign o_head_addr      = r_addr[r_head];
  assign o_head_mask      = r_mask[r_head];
  assign o_head_wdata     = r_wdata[r_head];
  assign o_head_rs1_rdata = r_rs1[r_head];
  assign o_head_rs2_rdata = r_rs2[r_head];

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_load_store_queue;

  localparam int DN = 8;

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid, enq_is_load, agu_valid, deq;
  logic [2:0]  enq_f3;
  logic [3:0]  enq_rob, agu_rob;
  logic [4:0]  enq_ar;
  logic [5:0]  enq_pr;
  logic [31:0] agu_addr, agu_rs1, agu_rs2;

  logic        full, head_is_load, head_ready;
  logic [3:0]  elemcount, head_rob, head_mask;
  logic [2:0]  head_f3;
  logic [4:0]  head_ar;
  logic [5:0]  head_pr;
  logic [31:0] head_addr, head_wdata, head_rs1, head_rs2;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH_BITS(3), .ROB_DEPTH_BITS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_rob_flush(flush),
    .i_enq_valid(enq_valid), .i_enq_is_load(enq_is_load), .i_enq_funct3(enq_f3),
    .i_enq_rob_id(enq_rob), .i_enq_ar_dest(enq_ar), .i_enq_pr_dest(enq_pr),
    .o_full(full), .o_elemcount(elemcount),
    .i_agu_valid(agu_valid), .i_agu_rob_id(agu_rob), .i_agu_addr(agu_addr),
    .i_agu_rs1_rdata(agu_rs1), .i_agu_rs2_rdata(agu_rs2),
    .o_head_is_load(head_is_load), .o_head_funct3(head_f3), .o_head_rob_id(head_rob),
    .o_head_ar_dest(head_ar), .o_head_pr_dest(head_pr), .o_head_ready(head_ready),
    .o_head_addr(head_addr), .o_head_mask(head_mask), .o_head_wdata(head_wdata),
    .o_head_rs1_rdata(head_rs1), .o_head_rs2_rdata(head_rs2), .i_dequeue(deq)
  );

  typedef struct {
    logic       is_load;
    logic [2:0] f3;
    logic [3:0] rob;
    logic [4:0] ar;
    logic [5:0] pr;
    bit         rdy;
  } op_t;

  op_t         mq[$];   // reference queue contents
  op_t         sb[$];   // expected dequeue order
  logic [31:0] ag_addr [16];
  logic [31:0] ag_rs1  [16];
  logic [31:0] ag_rs2  [16];
  logic [3:0]  next_rob = 4'd1;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Access size in bytes, aligned down offset, lanes covered and data shifted onto them
  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    int sz, off, m;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = (int'(addr[1:0]) / sz) * sz;
    m   = ((1 << sz) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rs2);
    int sz, off;
    logic [63:0] w;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = (int'(addr[1:0]) / sz) * sz;
    w   = {32'h0, rs2} << (8 * off);
    return w[31:0];
  endfunction

  // Advance the reference by one clock using the inputs that were applied during it
  task automatic apply_model();
    int n;
    op_t e;
    if (rst || flush) begin
      mq.delete();
      sb.delete();
      return;
    end
    n = mq.size();
    if (agu_valid) begin
      foreach (mq[k]) begin
        if (mq[k].rob == agu_rob) begin
          mq[k].rdy        = 1'b1;
          ag_addr[agu_rob] = agu_addr;
          ag_rs1[agu_rob]  = agu_rs1;
          ag_rs2[agu_rob]  = agu_rs2;
        end
      end
    end
    if (enq_valid && n < DN) begin
      e.is_load = enq_is_load; e.f3 = enq_f3; e.rob = enq_rob;
      e.ar = enq_ar; e.pr = enq_pr; e.rdy = 1'b0;
      mq.push_back(e);
      sb.push_back(e);
      next_rob++;
    end
    if (deq && n != 0) mq.delete(0);
  endtask

  task automatic idle();
    flush = 1'b0; enq_valid = 1'b0; agu_valid = 1'b0; deq = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    apply_model();
    #1;
    idle();
  endtask

  task automatic set_enq(input logic is_load, input logic [2:0] f3);
    enq_valid = 1'b1; enq_is_load = is_load; enq_f3 = f3; enq_rob = next_rob;
    enq_ar = 5'($urandom); enq_pr = 6'($urandom);
  endtask

  task automatic rand_enq();
    logic l;
    l = 1'($urandom);
    if (l) set_enq(1'b1, ld_f3[$urandom_range(4)]);
    else   set_enq(1'b0, 3'($urandom_range(2)));
  endtask

  task automatic set_agu(input logic [3:0] rob, input logic [31:0] addr, input logic [31:0] rs2);
    agu_valid = 1'b1; agu_rob = rob; agu_addr = addr; agu_rs1 = $urandom; agu_rs2 = rs2;
  endtask

  // Service the head: fill it if pending, otherwise pop it
  task automatic service_head();
    if (mq.size() > 0) begin
      if (!mq[0].rdy) set_agu(mq[0].rob, $urandom, $urandom);
      else            deq = 1'b1;
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && mq.size() > 0; g++) begin
      service_head();
      tick();
    end
    chk("drain_empty", 64'(elemcount), 64'd0);
  endtask

  // Monitor: status every cycle, full entry comparison on each observed pop
  initial begin
    op_t e;
    bit  exp_rdy;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_rdy = 1'b0;
        if (mq.size() != 0) exp_rdy = mq[0].rdy;
        chk("elemcount", 64'(elemcount), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DN));
        chk("head_ready", 64'(head_ready), 64'(exp_rdy));
        if (deq && head_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL deq_unexpected: actual rob=%0h expected none", head_rob);
          end else begin
            e = sb.pop_front();
            chk("deq_rob", 64'(head_rob), 64'(e.rob));
            chk("deq_is_load", 64'(head_is_load), 64'(e.is_load));
            chk("deq_funct3", 64'(head_f3), 64'(e.f3));
            chk("deq_ar", 64'(head_ar), 64'(e.ar));
            chk("deq_pr", 64'(head_pr), 64'(e.pr));
            chk("deq_addr", 64'(head_addr), 64'(ag_addr[e.rob]));
            chk("deq_mask", 64'(head_mask), 64'(ref_mask(e.f3, ag_addr[e.rob])));
            chk("deq_rs1", 64'(head_rs1), 64'(ag_rs1[e.rob]));
            chk("deq_rs2", 64'(head_rs2), 64'(ag_rs2[e.rob]));
            if (!e.is_load)
              chk("deq_wdata", 64'(head_wdata), 64'(ref_wdata(e.f3, ag_addr[e.rob], ag_rs2[e.rob])));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb, rc, rx;
    int k;
    enq_is_load = 1'b0; enq_f3 = '0; enq_rob = '0; enq_ar = '0; enq_pr = '0;
    agu_rob = '0; agu_addr = '0; agu_rs1 = '0; agu_rs2 = '0;
    idle();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_elemcount", 64'(elemcount), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_head_ready", 64'(head_ready), 64'd0);

    // Three ops, then byte and half store alignment
    set_enq(1'b0, 3'd0); tick();
    set_enq(1'b0, 3'd1); tick();
    set_enq(1'b1, 3'd2); tick();
    chk("t1_elemcount", 64'(elemcount), 64'd3);
    chk("t1_head_rob", 64'(head_rob), 64'd1);
    chk("t1_head_ready", 64'(head_ready), 64'd0);
    set_agu(4'd1, 32'h0000_1003, 32'h0000_00AB); tick();
    chk("sb_ready", 64'(head_ready), 64'd1);
    chk("sb_mask", 64'(head_mask), 64'h8);
    chk("sb_wdata", 64'(head_wdata), 64'hAB00_0000);
    set_agu(4'd2, 32'h0000_2002, 32'h1234_5678); deq = 1'b1; tick();
    chk("sh_rob", 64'(head_rob), 64'd2);
    chk("sh_mask", 64'(head_mask), 64'hC);
    chk("sh_wdata", 64'(head_wdata), 64'h5678_0000);
    set_agu(4'd3, 32'h0000_3000, $urandom); deq = 1'b1; tick();
    chk("lw_rob", 64'(head_rob), 64'd3);
    deq = 1'b1; tick();
    chk("t1_empty", 64'(elemcount), 64'd0);

    // Fill, drop an enqueue while full, then cycle through the wrap
    for (int i = 0; i < DN; i++) begin rand_enq(); tick(); end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(elemcount), 64'd8);
    set_agu(mq[0].rob, $urandom, $urandom); tick();
    rand_enq(); deq = 1'b1; tick();
    chk("drop_count", 64'(elemcount), 64'd7);
    chk("drop_full", 64'(full), 64'd0);
    chk("drop_head", 64'(head_rob), 64'd5);
    for (int i = 0; i < 20; i++) begin rand_enq(); service_head(); tick(); end
    drain();

    // Out-of-order address generation holds the head
    ra = next_rob; rb = ra + 4'd1; rc = ra + 4'd2;
    for (int i = 0; i < 3; i++) begin rand_enq(); tick(); end
    set_agu(rc, $urandom, $urandom); tick();
    chk("ooo_c", 64'(head_ready), 64'd0);
    set_agu(rb, $urandom, $urandom); tick();
    chk("ooo_b", 64'(head_ready), 64'd0);
    set_agu(ra, $urandom, $urandom); tick();
    chk("ooo_a", 64'(head_ready), 64'd1);
    deq = 1'b1; tick();
    chk("b2b_rob_b", 64'(head_rob), 64'(rb));
    chk("b2b_ready_b", 64'(head_ready), 64'd1);
    deq = 1'b1; tick();
    chk("b2b_rob_c", 64'(head_rob), 64'(rc));
    chk("b2b_ready_c", 64'(head_ready), 64'd1);
    deq = 1'b1; tick();
    chk("ooo_empty", 64'(elemcount), 64'd0);

    // Flush beats a simultaneous enqueue and dequeue
    for (int i = 0; i < 5; i++) begin rand_enq(); tick(); end
    set_agu(mq[0].rob, $urandom, $urandom); tick();
    flush = 1'b1; rand_enq(); deq = 1'b1; tick();
    chk("flush_count", 64'(elemcount), 64'd0);
    chk("flush_ready", 64'(head_ready), 64'd0);
    chk("flush_full", 64'(full), 64'd0);
    rx = next_rob;
    set_enq(1'b1, 3'd2); tick();
    chk("post_flush_count", 64'(elemcount), 64'd1);
    chk("post_flush_rob", 64'(head_rob), 64'(rx));
    chk("post_flush_ready", 64'(head_ready), 64'd0);
    drain();

    // Dequeue and unmatched AGU on an empty queue
    deq = 1'b1; set_agu(next_rob + 4'd7, $urandom, $urandom); tick();
    chk("empty_count", 64'(elemcount), 64'd0);
    chk("empty_ready", 64'(head_ready), 64'd0);
    chk("empty_full", 64'(full), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) flush = 1'b1;
      if ($urandom_range(99) < 55) rand_enq();
      if (mq.size() > 0 && $urandom_range(99) < 60) begin
        k = $urandom_range(mq.size() - 1);
        if (!mq[k].rdy) set_agu(mq[k].rob, $urandom, $urandom);
      end else if ($urandom_range(15) == 0) begin
        rx = 4'($urandom);
        if (!(enq_valid && rx == enq_rob)) set_agu(rx, $urandom, $urandom);
      end
      if (mq.size() > 0) begin
        if (mq[0].rdy && $urandom_range(99) < 70) deq = 1'b1;
      end else if ($urandom_range(9) == 0) begin
        deq = 1'b1;
      end
      tick();
    end
    drain();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
